modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, exponent word width; TOTAL_ADDR, default 128, exponent word count; ADDR_W, default clog2(TOTAL_ADDR), e_addr width.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset; start in 1 begin exponentiation; abort in 1 cancel run; e_addr out ADDR_W exponent word address; e_data in DATA_WIDTH exponent word, valid 1 cycle after e_addr; mp_start out 1 one-cycle MonPro launch; mp_op out 3 MonPro operand select; mp_done in 1 one-cycle MonPro completion; busy out 1 run in progress; done out 1 one-cycle completion pulse.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 mp_op encodings SHALL be: OP_TOMONT=0 (Mbar=MonPro(M,R2)), OP_INIT=1 (A=MonPro(R2,1)), OP_SQR=2 (A=MonPro(A,A)), OP_MUL=3 (A=MonPro(A,Mbar)), OP_FROM=4 (A=MonPro(A,1)).
REQ-005 States SHALL be IDLE, ISSUE, WAIT, FETCH, LATCH, DONE.
REQ-006 In IDLE, start=1 SHALL load word index = TOTAL_ADDR-1, set the pending op to OP_TOMONT, and go to ISSUE next cycle.
REQ-007 ISSUE SHALL assert mp_start=1 with mp_op=pending op for exactly one cycle, then go to WAIT.
REQ-008 WAIT SHALL hold mp_start=0 and keep mp_op stable until mp_done=1; on that cycle the next transition SHALL be selected per REQ-009.
REQ-009 The op sequence SHALL be: OP_TOMONT -> OP_INIT -> FETCH; after OP_SQR, an OP_MUL if the current exponent bit is 1, else next bit; after OP_MUL, next bit; after OP_FROM -> DONE.
REQ-010 FETCH SHALL drive e_addr = word index for one cycle; LATCH SHALL capture e_data into a DATA_WIDTH shift register, reset the bit counter to DATA_WIDTH-1, and go to ISSUE with OP_SQR.
REQ-011 Bits SHALL be processed MSB first: word TOTAL_ADDR-1 bit DATA_WIDTH-1 down to word 0 bit 0; no leading zeros are skipped (fixed op count).
REQ-012 "Next bit" SHALL shift the register left by 1 and decrement the bit counter; when the counter was 0: if word index = 0, pending op = OP_FROM; else decrement word index and go to FETCH.
REQ-013 Total MonPro launches per run SHALL be 3 + DATA_WIDTH*TOTAL_ADDR + popcount(exponent).
REQ-014 DONE SHALL assert done=1 for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 mp_done in any state other than WAIT SHALL be ignored.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE next cycle with mp_start=0, busy=0, and no done pulse; abort has priority over mp_done and start in the same cycle.
REQ-018 e_addr SHALL hold its last value outside FETCH.

Reset
REQ-019 reset SHALL force IDLE with mp_start=0, done=0, busy=0, mp_op=OP_TOMONT, e_addr=0, counters and shift register 0; reset SHALL take priority over abort, start and mp_done.
REQ-020 reset asserted mid-run SHALL discard all progress; no done pulse SHALL follow.

Structure
REQ-021 DATA_WIDTH, TOTAL_ADDR and the OP_* encodings SHALL live in the shared parameter include used by the MonPro datapath.
REQ-022 The block SHALL be a single FSM with no sub-modules; the MonPro engine is external and driven only via mp_start/mp_op/mp_done.

Verification
REQ-023 Benches SHALL use DATA_WIDTH=4, TOTAL_ADDR=2 with a MonPro stub returning mp_done 3 cycles after mp_start.
REQ-024 Exponent words {1:0x0,0:0x0} -> ops TOMONT, INIT, 8x SQR, FROM (11 launches), one done pulse.
REQ-025 Exponent {1:0xF,0:0xF} -> TOMONT, INIT, 8x (SQR,MUL), FROM (19 launches).
REQ-026 Exponent {1:0x8,0:0x1} -> TOMONT, INIT, SQR, MUL, 6x SQR, SQR, MUL, FROM (13 launches); e_addr 1 then 0.
REQ-027 start pulsed during WAIT of first OP_SQR -> ignored, op sequence unchanged; spurious mp_done in IDLE -> no state change.
REQ-028 abort in WAIT of OP_MUL -> IDLE next cycle, no done; reset during FETCH -> IDLE, all outputs at reset values; new start then runs a full sequence.

Source files
------------

// File: rtl/modexp_ctrl_pkg.sv
// Shared MonPro parameters: default exponent geometry, MonPro operand selects, controller states.
// Imported by the exponent controller and the MonPro datapath so the op encodings stay in one place.
package modexp_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TOTAL_ADDR = 128;

  typedef enum logic [2:0] {
    OP_TOMONT = 3'd0,  // Mbar = MonPro(M, R2)
    OP_INIT   = 3'd1,  // A    = MonPro(R2, 1)
    OP_SQR    = 3'd2,  // A    = MonPro(A, A)
    OP_MUL    = 3'd3,  // A    = MonPro(A, Mbar)
    OP_FROM   = 3'd4   // A    = MonPro(A, 1)
  } mp_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FETCH = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer: walks every exponent bit MSB first and launches MonPro ops.
// One op in flight at a time; each launch waits for mp_done, so a slow MonPro engine simply stretches WAIT.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TOTAL_ADDR = DEF_TOTAL_ADDR,
  parameter int ADDR_W     = $clog2(TOTAL_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     e_addr,
  input  logic [DATA_WIDTH-1:0] e_data,
  output logic                  mp_start,
  output logic [2:0]            mp_op,
  input  logic                  mp_done,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  mp_op_t                op_q, op_d;
  logic [ADDR_W-1:0]     word_q, word_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_TOMONT;
      word_q  <= '0;
      addr_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = ADDR_W'(TOTAL_ADDR - 1);
          op_d    = OP_TOMONT;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mp_done) begin
          case (op_q)
            OP_TOMONT: begin
              op_d    = OP_INIT;
              state_d = ISSUE;
            end
            OP_INIT: state_d = FETCH;
            OP_SQR: begin
              // The bit under test always sits at the shift register MSB.
              if (sh_q[DATA_WIDTH-1]) begin
                op_d    = OP_MUL;
                state_d = ISSUE;
              end else begin
                adv = 1'b1;
              end
            end
            OP_MUL:  adv = 1'b1;
            OP_FROM: state_d = DONE;
            default: state_d = IDLE;
          endcase
        end
      end
      FETCH: begin
        addr_d  = word_q;
        state_d = LATCH;
      end
      LATCH: begin
        sh_d    = e_data;
        bit_d   = BW'(DATA_WIDTH - 1);
        op_d    = OP_SQR;
        state_d = ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (adv) begin
      sh_d  = sh_q << 1;
      bit_d = bit_q - BW'(1);
      if (bit_q != '0) begin
        op_d    = OP_SQR;
        state_d = ISSUE;
      end else if (word_q == '0) begin
        op_d    = OP_FROM;
        state_d = ISSUE;
      end else begin
        word_d  = word_q - ADDR_W'(1);
        state_d = FETCH;
      end
    end

    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // The address is live during FETCH so a registered exponent RAM answers in LATCH.
  assign e_addr   = (state_q == FETCH) ? word_q : addr_q;
  assign mp_start = (state_q == ISSUE);
  assign mp_op    = op_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: 4-bit words x 2, registered exponent RAM and a 3-cycle MonPro stub.
module tb_modexp_ctrl;

  localparam int DW = 4;
  localparam int TA = 2;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          reset, start, abort, mp_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          mp_start, busy, done;
  logic [2:0]    mp_op;

  always #5 clk = ~clk;

  modexp_ctrl #(.DATA_WIDTH(DW), .TOTAL_ADDR(TA), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .e_addr(e_addr), .e_data(e_data), .mp_start(mp_start), .mp_op(mp_op),
    .mp_done(mp_done), .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [TA];
  always @(posedge clk) e_data <= mem[e_addr];

  logic [2:0] sr;
  logic       inj_done;
  always @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= {sr[1:0], mp_start};
  end
  assign mp_done = sr[2] | inj_done;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the op list and the word address expected at each word's first square.
  int exp_ops[$];
  int exp_addr[$];

  task automatic build_model(input logic [DW-1:0] w1, input logic [DW-1:0] w0);
    logic [DW-1:0] words [TA];
    words[1] = w1;
    words[0] = w0;
    exp_ops  = {};
    exp_addr = {};
    exp_ops.push_back(0); exp_addr.push_back(-1);
    exp_ops.push_back(1); exp_addr.push_back(-1);
    for (int w = TA - 1; w >= 0; w--) begin
      for (int b = DW - 1; b >= 0; b--) begin
        exp_ops.push_back(2);
        exp_addr.push_back((b == DW - 1) ? w : -1);
        if (words[w][b]) begin
          exp_ops.push_back(3);
          exp_addr.push_back(-1);
        end
      end
    end
    exp_ops.push_back(4); exp_addr.push_back(-1);
  endtask

  int launch_idx = 0;
  int done_cnt   = 0;
  int last_op    = 0;
  bit checking   = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (checking) begin
      if (mp_start) begin
        if (launch_idx < exp_ops.size()) begin
          chk("op", mp_op, exp_ops[launch_idx]);
          if (exp_addr[launch_idx] >= 0) chk("e_addr", e_addr, exp_addr[launch_idx]);
        end else begin
          chk("launch_count", launch_idx + 1, exp_ops.size());
        end
        last_op = mp_op;
        launch_idx++;
      end
      if (mp_done && busy) chk("op_stable", mp_op, last_op);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mp_start"}, mp_start, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mp_op"}, mp_op, 0);
    chk({tag, "_e_addr"}, e_addr, 0);
  endtask

  task automatic quiet(input string tag);
    int starts = 0;
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (mp_start) starts++;
    end
    chk({tag, "_quiet_launch"}, starts, 0);
    chk({tag, "_quiet_done"}, done_cnt, 0);
  endtask

  // mode 0: plain run, 1: start pulsed in WAIT of first SQR,
  // 2: abort in WAIT of first MUL, 3: reset during first FETCH
  task automatic run(input logic [DW-1:0] w1, input logic [DW-1:0] w0, input int mode);
    int n = 0;
    bit injected = 1'b0;
    bit cut = 1'b0;
    mem[1] = w1;
    mem[0] = w0;
    build_model(w1, w0);
    launch_idx = 0;
    done_cnt   = 0;
    last_op    = 0;
    checking   = 1'b1;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    while (done_cnt == 0 && n < 400 && !cut) begin
      @(posedge clk); #2;
      n++;
      if (mode == 1 && !injected && launch_idx == 3 && !mp_start) begin
        chk("busy_when_restart", busy, 1);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        injected = 1'b1;
      end
      if (mode == 2 && launch_idx == 4 && !mp_start) begin
        abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        checking = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mp_start", mp_start, 0);
        cut = 1'b1;
      end
      if (mode == 3 && launch_idx == 2 && mp_done) begin
        @(posedge clk); #2;
        chk("fetch_addr", e_addr, 1);
        reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        checking = 1'b0;
        check_reset_vals("midrun_reset");
        cut = 1'b1;
      end
    end
    if (cut) begin
      quiet((mode == 2) ? "abort" : "reset");
    end else begin
      chk("done_seen", done_cnt, 1);
      repeat (3) @(posedge clk);
      #2;
      checking = 1'b0;
      chk("launches", launch_idx, exp_ops.size());
      chk("done_pulses", done_cnt, 1);
      chk("busy_after", busy, 0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    inj_done = 1'b0;
    mem[0]   = '0;
    mem[1]   = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    reset = 1'b0;

    build_model(4'h0, 4'h0);
    chk("model_len_00", exp_ops.size(), 11);
    build_model(4'hF, 4'hF);
    chk("model_len_ff", exp_ops.size(), 19);
    chk("model_ff_op3", exp_ops[3], 3);
    build_model(4'h8, 4'h1);
    chk("model_len_81", exp_ops.size(), 13);
    chk("model_81_op4", exp_ops[4], 2);
    chk("model_81_op11", exp_ops[11], 3);
    chk("model_81_op12", exp_ops[12], 4);

    run(4'h0, 4'h0, 0);
    run(4'hF, 4'hF, 0);
    run(4'h8, 4'h1, 0);
    run(4'hA, 4'h5, 0);

    @(posedge clk); #2 inj_done = 1'b1;
    @(posedge clk); #2 inj_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spurious_busy", busy, 0);
      chk("spurious_mp_start", mp_start, 0);
      @(posedge clk); #2;
    end

    run(4'h8, 4'h1, 1);
    run(4'h8, 4'h1, 2);
    run(4'hF, 4'hF, 3);
    run(4'hF, 4'hF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
